// File: rtl/pll_phase_pkg.sv
// Shared types for the PLL dynamic-phase controller: FSM state encoding and select-mask bit positions.
package pll_phase_pkg;

    typedef enum logic [2:0] {
        ST_PWRDN,
        ST_WAIT_LOCK,
        ST_IDLE,
        ST_SETUP,
        ST_ROT_HI,
        ST_ROT_LO,
        ST_LOAD,
        ST_DONE
    } state_t;

    localparam int SEL_W    = 3;
    localparam int SEL_OUT0 = 0;
    localparam int SEL_OUT2 = 1;
    localparam int SEL_OUT3 = 2;

    // States in which a phase request is actively driving the PLL port.
    function automatic logic in_request(input state_t s);
        return (s == ST_SETUP) || (s == ST_ROT_HI) || (s == ST_ROT_LO) || (s == ST_LOAD);
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser bringing the asynchronous PLL lock indication into the fabric clock domain.
module pll_lock_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/pll_phase_shift_ctrl.sv
// Fabric-side initiator for the CCC PLL dynamic-phase port: power-up, lock qualification,
// rotate/load sequencing of phase-step requests and per-output phase offset tracking.
module pll_phase_shift_ctrl
    import pll_phase_pkg::*;
#(
    parameter int STEP_W         = 6,
    parameter int ACC_W          = 6,
    parameter int SETUP_CYCLES   = 2,
    parameter int PULSE_CYCLES   = 2,
    parameter int POWERUP_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pd_req,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [SEL_W-1:0]  req_sel,
    input  logic              req_dir,
    input  logic [STEP_W-1:0] req_steps,
    output logic              done,
    output logic              err,
    output logic              locked,
    output logic [ACC_W-1:0]  phase0,
    output logic [ACC_W-1:0]  phase2,
    output logic [ACC_W-1:0]  phase3,
    input  logic              pll_lock,
    output logic              pll_powerdown_n,
    output logic              phase_out0_sel,
    output logic              phase_out2_sel,
    output logic              phase_out3_sel,
    output logic              phase_direction,
    output logic              phase_rotate,
    output logic              load_phase_n
);

    localparam int CNT_W = $clog2(LOCK_TIMEOUT + POWERUP_CYCLES + SETUP_CYCLES + PULSE_CYCLES + 1);

    localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);

    function automatic logic [ACC_W-1:0] step_phase(input logic [ACC_W-1:0] p, input logic inc);
        return inc ? p + ACC_W'(1) : p - ACC_W'(1);
    endfunction

    logic lock_s;

    pll_lock_sync u_lock_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (pll_lock),
        .sync_out (lock_s)
    );

    state_t            state_q, state_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;
    logic [STEP_W-1:0] steps_q, steps_nxt;
    logic              pd_n_q, pd_n_nxt;
    logic              sel0_q, sel0_nxt;
    logic              sel2_q, sel2_nxt;
    logic              sel3_q, sel3_nxt;
    logic              dir_q, dir_nxt;
    logic              rot_q, rot_nxt;
    logic              load_n_q, load_n_nxt;
    logic              err_q, err_nxt;
    logic              locked_q, locked_nxt;
    logic [ACC_W-1:0]  ph0_q, ph0_nxt;
    logic [ACC_W-1:0]  ph2_q, ph2_nxt;
    logic [ACC_W-1:0]  ph3_q, ph3_nxt;
    logic              rot_enter;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_PWRDN;
            cnt_q    <= '0;
            steps_q  <= '0;
            pd_n_q   <= 1'b0;
            sel0_q   <= 1'b0;
            sel2_q   <= 1'b0;
            sel3_q   <= 1'b0;
            dir_q    <= 1'b0;
            rot_q    <= 1'b0;
            load_n_q <= 1'b1;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
            ph0_q    <= '0;
            ph2_q    <= '0;
            ph3_q    <= '0;
        end else begin
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            steps_q  <= steps_nxt;
            pd_n_q   <= pd_n_nxt;
            sel0_q   <= sel0_nxt;
            sel2_q   <= sel2_nxt;
            sel3_q   <= sel3_nxt;
            dir_q    <= dir_nxt;
            rot_q    <= rot_nxt;
            load_n_q <= load_n_nxt;
            err_q    <= err_nxt;
            locked_q <= locked_nxt;
            ph0_q    <= ph0_nxt;
            ph2_q    <= ph2_nxt;
            ph3_q    <= ph3_nxt;
        end
    end

    always_comb begin
        state_nxt  = state_q;
        cnt_nxt    = cnt_q;
        steps_nxt  = steps_q;
        pd_n_nxt   = pd_n_q;
        sel0_nxt   = sel0_q;
        sel2_nxt   = sel2_q;
        sel3_nxt   = sel3_q;
        dir_nxt    = dir_q;
        rot_nxt    = rot_q;
        load_n_nxt = load_n_q;
        err_nxt    = err_q;
        locked_nxt = locked_q;
        ph0_nxt    = ph0_q;
        ph2_nxt    = ph2_q;
        ph3_nxt    = ph3_q;
        rot_enter  = 1'b0;

        if (in_request(state_q) && !lock_s) begin
            // Lock lost mid-request: release the port, keep the steps already issued.
            state_nxt  = ST_WAIT_LOCK;
            cnt_nxt    = '0;
            sel0_nxt   = 1'b0;
            sel2_nxt   = 1'b0;
            sel3_nxt   = 1'b0;
            dir_nxt    = 1'b0;
            rot_nxt    = 1'b0;
            load_n_nxt = 1'b1;
            err_nxt    = 1'b1;
            locked_nxt = 1'b0;
        end else begin
            case (state_q)
                ST_PWRDN: begin
                    pd_n_nxt = 1'b0;
                    if (cnt_q == PWR_LAST) begin
                        cnt_nxt   = '0;
                        pd_n_nxt  = 1'b1;
                        state_nxt = ST_WAIT_LOCK;
                    end else begin
                        cnt_nxt = cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        cnt_nxt    = '0;
                        locked_nxt = 1'b1;
                        state_nxt  = ST_IDLE;
                    end else if (cnt_q == LOCK_LAST) begin
                        cnt_nxt   = '0;
                        err_nxt   = 1'b1;
                        pd_n_nxt  = 1'b0;
                        state_nxt = ST_PWRDN;
                    end else begin
                        cnt_nxt = cnt_q + CNT_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (!lock_s) begin
                        locked_nxt = 1'b0;
                        cnt_nxt    = '0;
                        state_nxt  = ST_WAIT_LOCK;
                    end else if (req_valid) begin
                        err_nxt = 1'b0;
                        if ((req_steps == '0) || (req_sel == '0)) begin
                            state_nxt = ST_DONE;
                        end else begin
                            sel0_nxt  = req_sel[SEL_OUT0];
                            sel2_nxt  = req_sel[SEL_OUT2];
                            sel3_nxt  = req_sel[SEL_OUT3];
                            dir_nxt   = req_dir;
                            steps_nxt = req_steps;
                            cnt_nxt   = '0;
                            state_nxt = ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        cnt_nxt   = '0;
                        rot_nxt   = 1'b1;
                        rot_enter = 1'b1;
                        state_nxt = ST_ROT_HI;
                    end else begin
                        cnt_nxt = cnt_q + CNT_W'(1);
                    end
                end
                ST_ROT_HI: begin
                    if (cnt_q == PULSE_LAST) begin
                        cnt_nxt   = '0;
                        rot_nxt   = 1'b0;
                        steps_nxt = steps_q - STEP_W'(1);
                        state_nxt = ST_ROT_LO;
                    end else begin
                        cnt_nxt = cnt_q + CNT_W'(1);
                    end
                end
                ST_ROT_LO: begin
                    if (cnt_q == PULSE_LAST) begin
                        cnt_nxt = '0;
                        if (steps_q == '0) begin
                            load_n_nxt = 1'b0;
                            state_nxt  = ST_LOAD;
                        end else begin
                            rot_nxt   = 1'b1;
                            rot_enter = 1'b1;
                            state_nxt = ST_ROT_HI;
                        end
                    end else begin
                        cnt_nxt = cnt_q + CNT_W'(1);
                    end
                end
                ST_LOAD: begin
                    if (cnt_q == PULSE_LAST) begin
                        cnt_nxt    = '0;
                        load_n_nxt = 1'b1;
                        sel0_nxt   = 1'b0;
                        sel2_nxt   = 1'b0;
                        sel3_nxt   = 1'b0;
                        dir_nxt    = 1'b0;
                        state_nxt  = ST_DONE;
                    end else begin
                        cnt_nxt = cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_PWRDN;
                end
            endcase
        end

        // Phase offsets advance as each rotate pulse is launched.
        if (rot_enter) begin
            if (sel0_q) ph0_nxt = step_phase(ph0_q, dir_q);
            if (sel2_q) ph2_nxt = step_phase(ph2_q, dir_q);
            if (sel3_q) ph3_nxt = step_phase(ph3_q, dir_q);
        end

        // Power-down wins over everything; the PLL reloads its static phases on power-up.
        if (pd_req) begin
            if (in_request(state_q)) err_nxt = 1'b1;
            state_nxt  = ST_PWRDN;
            cnt_nxt    = '0;
            steps_nxt  = '0;
            pd_n_nxt   = 1'b0;
            sel0_nxt   = 1'b0;
            sel2_nxt   = 1'b0;
            sel3_nxt   = 1'b0;
            dir_nxt    = 1'b0;
            rot_nxt    = 1'b0;
            load_n_nxt = 1'b1;
            locked_nxt = 1'b0;
            ph0_nxt    = '0;
            ph2_nxt    = '0;
            ph3_nxt    = '0;
        end
    end

    assign req_ready       = (state_q == ST_IDLE) && lock_s;
    assign done            = (state_q == ST_DONE);
    assign err             = err_q;
    assign locked          = locked_q;
    assign phase0          = ph0_q;
    assign phase2          = ph2_q;
    assign phase3          = ph3_q;
    assign pll_powerdown_n = pd_n_q;
    assign phase_out0_sel  = sel0_q;
    assign phase_out2_sel  = sel2_q;
    assign phase_out3_sel  = sel3_q;
    assign phase_direction = dir_q;
    assign phase_rotate    = rot_q;
    assign load_phase_n    = load_n_q;

endmodule

// File: tb/tb_pll_phase_shift_ctrl.sv
// Directed bench for pll_phase_shift_ctrl at default parameters; samples 1 time unit after each rising edge.
module tb_pll_phase_shift_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       pd_req;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_sel;
    logic       req_dir;
    logic [5:0] req_steps;
    logic       done;
    logic       err;
    logic       locked;
    logic [5:0] phase0;
    logic [5:0] phase2;
    logic [5:0] phase3;
    logic       pll_lock;
    logic       pll_powerdown_n;
    logic       phase_out0_sel;
    logic       phase_out2_sel;
    logic       phase_out3_sel;
    logic       phase_direction;
    logic       phase_rotate;
    logic       load_phase_n;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pll_phase_shift_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .pd_req          (pd_req),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_sel         (req_sel),
        .req_dir         (req_dir),
        .req_steps       (req_steps),
        .done            (done),
        .err             (err),
        .locked          (locked),
        .phase0          (phase0),
        .phase2          (phase2),
        .phase3          (phase3),
        .pll_lock        (pll_lock),
        .pll_powerdown_n (pll_powerdown_n),
        .phase_out0_sel  (phase_out0_sel),
        .phase_out2_sel  (phase_out2_sel),
        .phase_out3_sel  (phase_out3_sel),
        .phase_direction (phase_direction),
        .phase_rotate    (phase_rotate),
        .load_phase_n    (load_phase_n)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for exactly one edge; returns just after the accepting edge (offset 0).
    task automatic issue(input logic [2:0] s, input logic d, input logic [5:0] n);
        req_sel   = s;
        req_dir   = d;
        req_steps = n;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; pd_req = 1'b0; req_valid = 1'b0; req_sel = 3'b000;
        req_dir = 1'b0; req_steps = 6'd0; pll_lock = 1'b0;
        repeat (3) tick();
        n_cmp++; if (pll_powerdown_n !== 1'b0) begin n_bad++; $display("FAIL reset_pd_n got %b want 0", pll_powerdown_n); end
        n_cmp++; if ({phase_out3_sel, phase_out2_sel, phase_out0_sel, phase_direction, phase_rotate} !== 5'b0) begin
            n_bad++; $display("FAIL reset_port got %b want 00000", {phase_out3_sel, phase_out2_sel, phase_out0_sel, phase_direction, phase_rotate}); end
        n_cmp++; if (load_phase_n !== 1'b1) begin n_bad++; $display("FAIL reset_load_n got %b want 1", load_phase_n); end
        n_cmp++; if ({req_ready, done, err, locked} !== 4'b0) begin n_bad++; $display("FAIL reset_status got %b want 0000", {req_ready, done, err, locked}); end
        n_cmp++; if ({phase0, phase2, phase3} !== 18'd0) begin n_bad++; $display("FAIL reset_phase got %h want 0", {phase0, phase2, phase3}); end
    endtask

    task automatic test_powerup_lock();
        reset = 1'b0;
        for (int e = 1; e <= 22; e++) begin
            tick();
            if (e == 15) begin n_cmp++; if (pll_powerdown_n !== 1'b0) begin n_bad++; $display("FAIL pwrup_e15 got %b want 0", pll_powerdown_n); end end
            if (e == 16) begin n_cmp++; if (pll_powerdown_n !== 1'b1) begin n_bad++; $display("FAIL pwrup_e16 got %b want 1", pll_powerdown_n); end end
            if (e == 19) pll_lock = 1'b1;
            if (e == 21) begin n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL lock_e21 got %b want 0", locked); end end
            if (e == 22) begin
                n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL lock_e22 got %b want 1", locked); end
                n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL ready_e22 got %b want 1", req_ready); end
            end
        end
    endtask

    task automatic test_rotate_inc();
        logic [16:0] rv, lv, dv, sv;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL inc_ready got %b want 1", req_ready); end
        issue(3'b101, 1'b1, 6'd3);
        for (int k = 0; k <= 16; k++) begin
            rv[k] = phase_rotate;
            lv[k] = ~load_phase_n;
            dv[k] = done;
            sv[k] = phase_out0_sel & phase_out3_sel & ~phase_out2_sel & phase_direction;
            if (k == 2) begin n_cmp++; if (phase0 !== 6'd1) begin n_bad++; $display("FAIL inc_first_step got %0d want 1", phase0); end end
            tick();
        end
        n_cmp++; if (rv !== 17'h00CCC) begin n_bad++; $display("FAIL inc_rotate got %h want 00ccc", rv); end
        n_cmp++; if (lv !== 17'h0C000) begin n_bad++; $display("FAIL inc_load got %h want 0c000", lv); end
        n_cmp++; if (dv !== 17'h10000) begin n_bad++; $display("FAIL inc_done got %h want 10000", dv); end
        n_cmp++; if (sv !== 17'h0FFFF) begin n_bad++; $display("FAIL inc_seldir got %h want 0ffff", sv); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL inc_ready_after got %b want 1", req_ready); end
        n_cmp++; if ({phase0, phase2, phase3} !== {6'd3, 6'd0, 6'd3}) begin
            n_bad++; $display("FAIL inc_phase got %0d/%0d/%0d want 3/0/3", phase0, phase2, phase3); end
    endtask

    task automatic test_dec_wrap();
        logic [8:0] rv, lv, dv, sv;
        issue(3'b010, 1'b0, 6'd1);
        for (int k = 0; k <= 8; k++) begin
            rv[k] = phase_rotate;
            lv[k] = ~load_phase_n;
            dv[k] = done;
            sv[k] = phase_out2_sel & ~phase_out0_sel & ~phase_out3_sel & ~phase_direction;
            tick();
        end
        n_cmp++; if (rv !== 9'h00C) begin n_bad++; $display("FAIL dec_rotate got %h want 00c", rv); end
        n_cmp++; if (lv !== 9'h0C0) begin n_bad++; $display("FAIL dec_load got %h want 0c0", lv); end
        n_cmp++; if (dv !== 9'h100) begin n_bad++; $display("FAIL dec_done got %h want 100", dv); end
        n_cmp++; if (sv !== 9'h0FF) begin n_bad++; $display("FAIL dec_seldir got %h want 0ff", sv); end
        n_cmp++; if ({phase0, phase2, phase3} !== {6'd3, 6'd63, 6'd3}) begin
            n_bad++; $display("FAIL dec_wrap got %0d/%0d/%0d want 3/63/3", phase0, phase2, phase3); end
    endtask

    task automatic test_zero_steps();
        issue(3'b111, 1'b1, 6'd0);
        n_cmp++; if ({done, req_ready, phase_rotate, load_phase_n, phase_out0_sel} !== 5'b10010) begin
            n_bad++; $display("FAIL zero_steps got %b want 10010", {done, req_ready, phase_rotate, load_phase_n, phase_out0_sel}); end
        tick();
        n_cmp++; if ({done, req_ready} !== 2'b01) begin n_bad++; $display("FAIL zero_steps_next got %b want 01", {done, req_ready}); end
        issue(3'b000, 1'b1, 6'd9);
        n_cmp++; if ({done, phase_rotate, load_phase_n} !== 3'b101) begin
            n_bad++; $display("FAIL zero_sel got %b want 101", {done, phase_rotate, load_phase_n}); end
        tick();
        n_cmp++; if ({phase0, phase2, phase3} !== {6'd3, 6'd63, 6'd3}) begin
            n_bad++; $display("FAIL zero_phase got %0d/%0d/%0d want 3/63/3", phase0, phase2, phase3); end
    endtask

    task automatic test_lock_loss();
        logic seen_done;
        seen_done = 1'b0;
        issue(3'b001, 1'b1, 6'd5);
        for (int k = 0; k <= 12; k++) begin
            seen_done = seen_done | done;
            if (k == 6) begin
                n_cmp++; if (phase_rotate !== 1'b1) begin n_bad++; $display("FAIL loss_2nd_hi got %b want 1", phase_rotate); end
                pll_lock = 1'b0;
            end
            if (k == 8) begin
                n_cmp++; if ({phase_out0_sel, err} !== 2'b10) begin n_bad++; $display("FAIL loss_pre got %b want 10", {phase_out0_sel, err}); end
            end
            if (k == 9) begin
                n_cmp++; if ({phase_rotate, phase_out0_sel, phase_direction, load_phase_n} !== 4'b0001) begin
                    n_bad++; $display("FAIL loss_port got %b want 0001", {phase_rotate, phase_out0_sel, phase_direction, load_phase_n}); end
                n_cmp++; if ({err, locked, req_ready} !== 3'b100) begin
                    n_bad++; $display("FAIL loss_status got %b want 100", {err, locked, req_ready}); end
            end
            tick();
        end
        n_cmp++; if (seen_done !== 1'b0) begin n_bad++; $display("FAIL loss_done got %b want 0", seen_done); end
        n_cmp++; if (phase0 !== 6'd5) begin n_bad++; $display("FAIL loss_phase0 got %0d want 5", phase0); end
        pll_lock = 1'b1;
        repeat (3) tick();
        n_cmp++; if ({req_ready, locked, err} !== 3'b111) begin n_bad++; $display("FAIL relock got %b want 111", {req_ready, locked, err}); end
        issue(3'b000, 1'b0, 6'd0);
        n_cmp++; if ({err, done} !== 2'b01) begin n_bad++; $display("FAIL err_clear got %b want 01", {err, done}); end
        tick();
    endtask

    task automatic test_idle_lock_loss();
        pll_lock = 1'b0;
        tick(); tick();
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL idle_loss_e2 got %b want 1", locked); end
        tick();
        n_cmp++; if ({locked, req_ready, err} !== 3'b000) begin n_bad++; $display("FAIL idle_loss got %b want 000", {locked, req_ready, err}); end
        pll_lock = 1'b1;
        repeat (3) tick();
        n_cmp++; if ({locked, req_ready} !== 2'b11) begin n_bad++; $display("FAIL idle_relock got %b want 11", {locked, req_ready}); end
    endtask

    task automatic test_pd_req();
        issue(3'b111, 1'b1, 6'd4);
        repeat (3) tick();
        n_cmp++; if (phase_rotate !== 1'b1) begin n_bad++; $display("FAIL pd_pre_rot got %b want 1", phase_rotate); end
        pd_req = 1'b1;
        tick();
        n_cmp++; if ({pll_powerdown_n, err, locked, done, req_ready} !== 5'b01000) begin
            n_bad++; $display("FAIL pd_status got %b want 01000", {pll_powerdown_n, err, locked, done, req_ready}); end
        n_cmp++; if ({phase_rotate, phase_out0_sel, phase_out2_sel, phase_out3_sel, load_phase_n} !== 5'b00001) begin
            n_bad++; $display("FAIL pd_port got %b want 00001", {phase_rotate, phase_out0_sel, phase_out2_sel, phase_out3_sel, load_phase_n}); end
        n_cmp++; if ({phase0, phase2, phase3} !== 18'd0) begin n_bad++; $display("FAIL pd_phase got %h want 0", {phase0, phase2, phase3}); end
        tick();
        pd_req = 1'b0;
        for (int e = 6; e <= 22; e++) begin
            tick();
            if (e == 20) begin n_cmp++; if (pll_powerdown_n !== 1'b0) begin n_bad++; $display("FAIL pd_release_e20 got %b want 0", pll_powerdown_n); end end
            if (e == 21) begin n_cmp++; if (pll_powerdown_n !== 1'b1) begin n_bad++; $display("FAIL pd_release_e21 got %b want 1", pll_powerdown_n); end end
            if (e == 22) begin n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL pd_relock got %b want 1", locked); end end
        end
    endtask

    task automatic test_timeout();
        reset = 1'b1;
        pll_lock = 1'b0;
        tick(); tick();
        reset = 1'b0;
        n_cmp++; if ({locked, err, pll_powerdown_n, req_ready} !== 4'b0000) begin
            n_bad++; $display("FAIL to_reset got %b want 0000", {locked, err, pll_powerdown_n, req_ready}); end
        for (int e = 1; e <= 4128; e++) begin
            tick();
            if (e == 16)   begin n_cmp++; if (pll_powerdown_n !== 1'b1) begin n_bad++; $display("FAIL to_pwrup got %b want 1", pll_powerdown_n); end end
            if (e == 4111) begin n_cmp++; if ({err, pll_powerdown_n} !== 2'b01) begin n_bad++; $display("FAIL to_before got %b want 01", {err, pll_powerdown_n}); end end
            if (e == 4112) begin n_cmp++; if ({err, pll_powerdown_n} !== 2'b10) begin n_bad++; $display("FAIL to_expire got %b want 10", {err, pll_powerdown_n}); end end
            if (e == 4127) begin n_cmp++; if (pll_powerdown_n !== 1'b0) begin n_bad++; $display("FAIL to_retry_low got %b want 0", pll_powerdown_n); end end
            if (e == 4128) begin n_cmp++; if (pll_powerdown_n !== 1'b1) begin n_bad++; $display("FAIL to_retry_up got %b want 1", pll_powerdown_n); end end
        end
    endtask

    initial begin
        test_reset();
        test_powerup_lock();
        test_rotate_inc();
        test_dec_wrap();
        test_zero_steps();
        test_lock_loss();
        test_idle_lock_loss();
        test_pd_req();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
